// File: rtl/cop_issue_bridge.sv
// Core-side issue bridge for the cop_ise co-processor: registers one request, drives it to the
// co-processor, and returns results in order through a small FIFO. Optional counters: COP_BRIDGE_PERF_EN.
module cop_issue_bridge #(
    parameter int TAG_W     = 5,
    parameter int RSP_DEPTH = 2,
    parameter int WAIT_MAX  = 16
) (
    input  logic             cop_clk,
    input  logic             cop_rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_insn,
    input  logic [63:0]      req_rs1,
    input  logic [63:0]      req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             cop_valid,
    output logic             cop_rdywr,
    input  logic             cop_ready,
    input  logic             cop_wait,
    input  logic             cop_wr,
    output logic [31:0]      cop_insn,
    output logic [63:0]      cop_rs1,
    output logic [63:0]      cop_rs2,
    input  logic [63:0]      cop_rd
`ifdef COP_BRIDGE_PERF_EN
    ,
    output logic [31:0]      perf_issue,
    output logic [31:0]      perf_stall,
    output logic [31:0]      perf_err
`endif
);

    localparam int PTR_W  = $clog2(RSP_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WCNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(RSP_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [WCNT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic [31:0]         insn_reg;
    logic [63:0]         rs1_reg;
    logic [63:0]         rs2_reg;
    logic [TAG_W-1:0]    tag_reg;

    logic [63:0]         data_mem [RSP_DEPTH];
    logic [TAG_W-1:0]    tag_mem  [RSP_DEPTH];
    logic                err_mem  [RSP_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;

    logic                accept;
    logic                pop;
    logic                push;
    logic                push_err;
    logic [63:0]         push_data;

    // cop_ready only mirrors the stall already visible as cop_wr && !cop_rdywr.
    logic                unused_cop_ready;
    assign unused_cop_ready = cop_ready;

    assign req_ready = cop_rst && (state_reg == IDLE);
    assign cop_valid = cop_rst && (state_reg != IDLE);
    assign cop_rdywr = (count_reg != FIFO_FULL);
    assign rsp_valid = (count_reg != '0);
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    assign cop_insn  = insn_reg;
    assign cop_rs1   = rs1_reg;
    assign cop_rs2   = rs2_reg;

    // Empty FIFO presents zeros so stale entries never leak onto the response bus.
    assign rsp_data  = rsp_valid ? data_mem[rd_ptr_reg] : '0;
    assign rsp_tag   = rsp_valid ? tag_mem[rd_ptr_reg]  : '0;
    assign rsp_err   = rsp_valid ? err_mem[rd_ptr_reg]  : 1'b0;

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        push          = 1'b0;
        push_err      = 1'b0;
        push_data     = '0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (cop_wr) begin
                    if (cop_rdywr) begin
                        push       = 1'b1;
                        push_data  = cop_rd;
                        state_next = IDLE;
                    end
                end else if (cop_wait) begin
                    state_next    = WAIT;
                    wait_cnt_next = '0;
                end else if (cop_rdywr) begin
                    push       = 1'b1;
                    push_err   = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (cop_wr && cop_rdywr) begin
                    push       = 1'b1;
                    push_data  = cop_rd;
                    state_next = IDLE;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    // Timed out: the counter parks here until the FIFO has room for the error.
                    if (cop_rdywr) begin
                        push       = 1'b1;
                        push_err   = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    wait_cnt_next = wait_cnt_reg + WCNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge cop_clk) begin
        if (!cop_rst) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            insn_reg     <= '0;
            rs1_reg      <= '0;
            rs2_reg      <= '0;
            tag_reg      <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (accept) begin
                insn_reg <= req_insn;
                rs1_reg  <= req_rs1;
                rs2_reg  <= req_rs2;
                tag_reg  <= req_tag;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage is left unreset; the pointers and count decide what is valid.
    always_ff @(posedge cop_clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= push_data;
            tag_mem[wr_ptr_reg]  <= tag_reg;
            err_mem[wr_ptr_reg]  <= push_err;
        end
    end

`ifdef COP_BRIDGE_PERF_EN
    always_ff @(posedge cop_clk) begin
        if (!cop_rst) begin
            perf_issue <= '0;
            perf_stall <= '0;
            perf_err   <= '0;
        end else begin
            if (push) begin
                perf_issue <= perf_issue + 32'd1;
            end
            if (cop_valid && !(cop_wr && cop_rdywr)) begin
                perf_stall <= perf_stall + 32'd1;
            end
            if (push && push_err) begin
                perf_err <= perf_err + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cop_issue_bridge.sv
// Self-checking bench for cop_issue_bridge: directed scenarios followed by randomized traffic,
// scored against an in-order queue of expected responses built from the request stream.
module tb_cop_issue_bridge;

    localparam int TAG_W    = 5;
    localparam int WAIT_MAX = 16;
    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

    logic             cop_clk;
    logic             cop_rst;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_insn;
    logic [63:0]      req_rs1;
    logic [63:0]      req_rs2;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic             cop_valid;
    logic             cop_rdywr;
    logic             cop_ready;
    logic             cop_wait;
    logic             cop_wr;
    logic [31:0]      cop_insn;
    logic [63:0]      cop_rs1;
    logic [63:0]      cop_rs2;
    logic [63:0]      cop_rd;
`ifdef COP_BRIDGE_PERF_EN
    logic [31:0]      perf_issue;
    logic [31:0]      perf_stall;
    logic [31:0]      perf_err;
`endif

    cop_issue_bridge #(.TAG_W(TAG_W), .RSP_DEPTH(2), .WAIT_MAX(WAIT_MAX)) dut (
        .cop_clk   (cop_clk),
        .cop_rst   (cop_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_insn  (req_insn),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err),
        .cop_valid (cop_valid),
        .cop_rdywr (cop_rdywr),
        .cop_ready (cop_ready),
        .cop_wait  (cop_wait),
        .cop_wr    (cop_wr),
        .cop_insn  (cop_insn),
        .cop_rs1   (cop_rs1),
        .cop_rs2   (cop_rs2),
        .cop_rd    (cop_rd)
`ifdef COP_BRIDGE_PERF_EN
        ,
        .perf_issue(perf_issue),
        .perf_stall(perf_stall),
        .perf_err  (perf_err)
`endif
    );

    typedef struct {
        logic [63:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } rsp_t;

    rsp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          rsp_policy = 0;   // 0: hold low, 1: always ready, 2: random
    int          n_push = 0;
    int          n_err  = 0;
    logic [63:0] cur_rd;

    initial cop_clk = 1'b0;
    always #5 cop_clk = ~cop_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, observed hang, required completion");
        $fatal(1, "watchdog");
    end

    // Reference co-processor: custom-0 rotates rs1 right by insn[30:25].
    function automatic logic [63:0] rotr(input logic [63:0] x, input int s);
        return (x >> s) | (x << (64 - s));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, choose rsp_ready, and score any pop happening this cycle.
    task automatic tick();
        rsp_t e;
        @(negedge cop_clk);
        case (rsp_policy)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", rsp_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_tag", rsp_tag, e.tag);
                check("rsp_err", rsp_err, e.err);
                $display("pop: tag=%0d data=%h err=%0d", rsp_tag, rsp_data, rsp_err);
            end
        end
    endtask

    task automatic accept_req(input logic [31:0] insn, input logic [63:0] a, input logic [63:0] b,
                              input logic [TAG_W-1:0] tg, input bit err_exp);
        int budget;
        rsp_t e;
        budget = 0;
        while (!req_ready && budget < 200) begin
            tick();
            budget++;
        end
        check("req_ready_before_issue", req_ready, 1);
        req_valid = 1'b1;
        req_insn  = insn;
        req_rs1   = a;
        req_rs2   = b;
        req_tag   = tg;
        cur_rd    = rotr(a, int'(insn[30:25]));
        e.data    = err_exp ? 64'd0 : cur_rd;
        e.tag     = tg;
        e.err     = err_exp;
        exp_q.push_back(e);
        n_push++;
        if (err_exp) n_err++;
        tick();
        req_valid = 1'b0;
        req_insn  = $urandom;
        req_rs1   = {$urandom, $urandom};
        req_rs2   = {$urandom, $urandom};
        req_tag   = TAG_W'($urandom);
        check("cop_valid_n1", cop_valid, 1);
        check("cop_insn", cop_insn, insn);
        check("cop_rs1", cop_rs1, a);
        check("cop_rs2", cop_rs2, b);
        check("req_ready_busy", req_ready, 0);
    endtask

    // mode 0: result at once, 1: unclaimed, 2: result after lat cop_wait cycles, 3: never completes
    task automatic finish_txn(input int mode, input int lat, output int vcyc);
        int k;
        k = 0;
        vcyc = 0;
        while (!req_ready && k < 200) begin
            if (cop_valid) vcyc++;
            case (mode)
                0:       begin cop_wr = 1'b1; cop_wait = 1'b0; end
                1:       begin cop_wr = 1'b0; cop_wait = 1'b0; end
                2:       begin cop_wr = (k >= lat); cop_wait = (k < lat); end
                default: begin cop_wr = 1'b0; cop_wait = 1'b1; end
            endcase
            cop_rd = cop_wr ? cur_rd : {$urandom, $urandom};
            tick();
            k++;
        end
        cop_wr   = 1'b0;
        cop_wait = 1'b0;
        check("txn_complete", req_ready, 1);
    endtask

    task automatic txn(input logic [31:0] insn, input logic [63:0] a, input logic [63:0] b,
                       input logic [TAG_W-1:0] tg, input int mode, input int lat, output int vcyc);
        accept_req(insn, a, b, tg, (mode == 1) || (mode == 3));
        finish_txn(mode, lat, vcyc);
        $display("txn: tag=%0d mode=%0d insn=%h cop_valid_cycles=%0d", tg, mode, insn, vcyc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        rsp_policy = 1;
        while (exp_q.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        check("drain_rsp_valid_low", rsp_valid, 0);
        check("drain_no_lost_rsp", exp_q.size(), 0);
    endtask

    initial begin
        int          vcyc;
        int          mode;
        int          lat;
        logic [31:0] insn;

        cop_rst = 1'b0; req_valid = 1'b0; req_insn = '0; req_rs1 = '0; req_rs2 = '0; req_tag = '0;
        rsp_ready = 1'b0; cop_ready = 1'b1; cop_wait = 1'b0; cop_wr = 1'b0; cop_rd = '0;

        // Reset values
        tick();
        tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_cop_valid", cop_valid, 0);
        check("rst_cop_insn", cop_insn, 0);
        check("rst_cop_rs1", cop_rs1, 0);
        check("rst_cop_rs2", cop_rs2, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_tag", rsp_tag, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_cop_rdywr", cop_rdywr, 1);
        cop_rst = 1'b1;
        tick();
        check("idle_req_ready", req_ready, 1);

        // Basic rotate: rori by 1 of 64'h1
        rsp_policy = 0;
        txn({7'b0000001, 18'd0, OPC_CUSTOM0}, 64'h1, 64'h0, 5'd3, 0, 0, vcyc);
        check("basic_cop_valid_cycles", vcyc, 1);
        check("basic_rsp_valid", rsp_valid, 1);
        check("basic_rsp_data", rsp_data, 64'h8000000000000000);
        check("basic_rsp_tag", rsp_tag, 3);
        check("basic_rsp_err", rsp_err, 0);
        drain();

        // Unclaimed instruction
        rsp_policy = 0;
        txn(32'h00B50533, 64'h1234, 64'h5678, 5'd7, 1, 0, vcyc);
        check("unclaimed_cycles", vcyc, 1);
        check("unclaimed_rsp_valid", rsp_valid, 1);
        check("unclaimed_rsp_err", rsp_err, 1);
        check("unclaimed_rsp_data", rsp_data, 0);
        check("unclaimed_rsp_tag", rsp_tag, 7);
        drain();

        // Back-pressure: two responses fill the FIFO, the third is held in ISSUE
        rsp_policy = 0;
        txn({7'd2, 18'd0, OPC_CUSTOM0}, 64'hA5, 64'h0, 5'd1, 0, 0, vcyc);
        txn({7'd3, 18'd0, OPC_CUSTOM0}, 64'h5A, 64'h0, 5'd2, 0, 0, vcyc);
        check("bp_full_rdywr", cop_rdywr, 0);
        accept_req({7'd4, 18'd0, OPC_CUSTOM0}, 64'hF0F0, 64'h0, 5'd3, 1'b0);
        cop_wr = 1'b1;
        cop_rd = cur_rd;
        for (int i = 0; i < 3; i++) begin
            check("bp_rdywr_low", cop_rdywr, 0);
            check("bp_cop_valid_held", cop_valid, 1);
            check("bp_req_ready_low", req_ready, 0);
            tick();
        end
        rsp_policy = 1;
        finish_txn(0, 0, vcyc);
        drain();

        // Timeout: exactly WAIT_MAX cycles in WAIT after the ISSUE cycle
        rsp_policy = 0;
        txn({7'd5, 18'd0, OPC_CUSTOM0}, 64'h77, 64'h0, 5'd11, 3, 0, vcyc);
        check("timeout_cop_valid_cycles", vcyc, 1 + WAIT_MAX);
        check("timeout_rsp_err", rsp_err, 1);
        check("timeout_rsp_data", rsp_data, 0);
        check("timeout_rsp_tag", rsp_tag, 11);
        drain();

        // Late result after 5 cop_wait cycles
        rsp_policy = 0;
        accept_req({7'd1, 18'd0, OPC_CUSTOM0}, 64'h1, 64'h0, 5'd12, 1'b0);
        exp_q[exp_q.size()-1].data = 64'hDEADBEEF01234567;
        cur_rd = 64'hDEADBEEF01234567;
        finish_txn(2, 5, vcyc);
        check("late_cop_valid_cycles", vcyc, 6);
        check("late_rsp_data", rsp_data, 64'hDEADBEEF01234567);
        check("late_rsp_err", rsp_err, 0);
        drain();

        // Reset in WAIT with one response buffered: both are dropped
        rsp_policy = 0;
        txn({7'd6, 18'd0, OPC_CUSTOM0}, 64'h99, 64'h0, 5'd9, 0, 0, vcyc);
        accept_req({7'd7, 18'd0, OPC_CUSTOM0}, 64'h42, 64'h0, 5'd10, 1'b0);
        cop_wait = 1'b1;
        repeat (3) tick();
        check("pre_rst_in_wait", cop_valid, 1);
        cop_rst = 1'b0;
        tick();
        check("midrst_req_ready", req_ready, 0);
        check("midrst_cop_valid", cop_valid, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        cop_rst  = 1'b1;
        cop_wait = 1'b0;
        exp_q.delete();
        n_push = 0;
        n_err  = 0;
        tick();
        check("postrst_req_ready", req_ready, 1);
        check("postrst_rsp_valid", rsp_valid, 0);
        check("postrst_cop_valid", cop_valid, 0);

        // Pointer wrap: five responses through a two-entry FIFO
        rsp_policy = 1;
        for (int i = 0; i < 5; i++) begin
            txn({7'($urandom), 18'($urandom), OPC_CUSTOM0}, {$urandom, $urandom}, {$urandom, $urandom},
                TAG_W'(20 + i), 0, 0, vcyc);
        end
        drain();

        // Randomized traffic with random consumer back-pressure
        rsp_policy = 2;
        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 9);
            mode = (mode < 5) ? 0 : (mode < 7) ? 1 : (mode < 9) ? 2 : 3;
            lat  = $urandom_range(1, WAIT_MAX);
            insn = $urandom;
            insn[6:0] = (mode == 1) ? 7'h33 : OPC_CUSTOM0;
            txn(insn, {$urandom, $urandom}, {$urandom, $urandom}, TAG_W'($urandom), mode, lat, vcyc);
        end
        drain();

`ifdef COP_BRIDGE_PERF_EN
        check("perf_issue", perf_issue, n_push);
        check("perf_err", perf_err, n_err);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
